// File: rtl/sq_drain.sv
// sq_drain: drains committed stores from the store-queue head to data memory.
// Tracks committed-but-undrained stores and writes or releases one head entry at a time.
module sq_drain #(
  parameter int PEND_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         commit_st,
  input  logic [73:0]                  sq_head,
  input  logic                         sq_empty,
  output logic                         del,
  output logic                         mem_req,
  output logic [7:0]                   mem_addr,
  output logic [31:0]                  mem_wdata,
  input  logic                         mem_ack,
  output logic [$clog2(PEND_DEPTH):0] pend_cnt,
  output logic                         busy,
  output logic                         overflow
);
  localparam int CW = $clog2(PEND_DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(PEND_DEPTH);
  typedef enum logic [1:0] {IDLE, WRITE, RELEASE} state_t;
  state_t state, state_nxt;
  logic ready, launch, full;
  logic [CW-1:0] pend_nxt;
  logic unused_pc;
  assign unused_pc = ^sq_head[72:41];
  assign del  = state == RELEASE;
  assign busy = state != IDLE;
  assign full = pend_cnt == FULL;
  always_comb begin
    ready     = pend_cnt != '0 && !sq_empty;
    state_nxt = state == IDLE  ? (ready && !sq_head[73] ? RELEASE : ready && sq_head[40] ? WRITE : IDLE) :
                state == WRITE ? (mem_ack ? RELEASE : WRITE) : IDLE;
    launch    = state == IDLE && state_nxt == WRITE;
    // a commit and a delete in the same cycle cancel; a commit at full is dropped
    pend_nxt  = commit_st && !del && !full ? pend_cnt + 1'b1 :
                del && !commit_st          ? pend_cnt - 1'b1 : pend_cnt;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      pend_cnt  <= '0;
      overflow  <= 1'b0;
    end else begin
      if (launch) begin
        mem_req   <= 1'b1;
        mem_addr  <= sq_head[39:32];
        mem_wdata <= sq_head[31:0];
      end else if (state == WRITE && mem_ack) begin
        mem_req <= 1'b0;
      end
      pend_cnt <= pend_nxt;
      overflow <= overflow | (commit_st && full && !del);
    end
  end
endmodule

// File: tb/tb_sq_drain.sv
// tb_sq_drain: directed checks of sq_drain latency, stalls, saturation and reset.
module tb_sq_drain;
  logic        clk = 1'b0;
  logic        rstn, commit_st, sq_empty, mem_ack;
  logic [73:0] sq_head;
  logic        del, mem_req, busy, overflow;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  pend_cnt;
  int          n_chk = 0, n_pass = 0;

  sq_drain #(.PEND_DEPTH(8)) dut (
    .clk(clk), .rstn(rstn), .commit_st(commit_st), .sq_head(sq_head), .sq_empty(sq_empty),
    .del(del), .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .pend_cnt(pend_cnt), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [73:0] mk(input logic v, input logic vd, input logic [7:0] a, input logic [31:0] d);
    return {v, 32'h0, vd, a, d};
  endfunction

  initial begin
    rstn = 1'b0; commit_st = 1'b0; sq_head = '0; sq_empty = 1'b1; mem_ack = 1'b0;
    #3;
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_pend", 32'(pend_cnt), 0);
    chk("rst_del", 32'(del), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_wdata", mem_wdata, 0);
    @(negedge clk) rstn = 1'b1;
    tick;
    chk("idle_busy", 32'(busy), 0);
    // minimum-latency write with ack tied high
    sq_empty = 1'b0; sq_head = mk(1, 1, 8'h2A, 32'hDEADBEEF); mem_ack = 1'b1; commit_st = 1'b1;
    tick; commit_st = 1'b0;
    chk("w_t1_pend", 32'(pend_cnt), 1);
    chk("w_t1_req", 32'(mem_req), 0);
    tick;
    chk("w_t2_req", 32'(mem_req), 1);
    chk("w_t2_addr", 32'(mem_addr), 32'h2A);
    chk("w_t2_data", mem_wdata, 32'hDEADBEEF);
    chk("w_t2_del", 32'(del), 0);
    tick;
    chk("w_t3_del", 32'(del), 1);
    chk("w_t3_req", 32'(mem_req), 0);
    tick;
    chk("w_t4_del", 32'(del), 0);
    chk("w_t4_busy", 32'(busy), 0);
    chk("w_t4_pend", 32'(pend_cnt), 0);
    // pending commit with empty queue stalls
    sq_empty = 1'b1; sq_head = mk(0, 0, 8'h77, 32'h0); commit_st = 1'b1;
    tick; commit_st = 1'b0;
    tick; tick;
    chk("emp_busy", 32'(busy), 0);
    chk("emp_pend", 32'(pend_cnt), 1);
    sq_empty = 1'b0;
    tick;
    chk("emp_del", 32'(del), 1);
    chk("emp_req", 32'(mem_req), 0);
    chk("emp_addr_keep", 32'(mem_addr), 32'h2A);
    tick;
    chk("emp_pend0", 32'(pend_cnt), 0);
    // squashed head: release two cycles after commit
    commit_st = 1'b1;
    tick; commit_st = 1'b0;
    chk("sq_t1_del", 32'(del), 0);
    chk("sq_t1_pend", 32'(pend_cnt), 1);
    tick;
    chk("sq_t2_del", 32'(del), 1);
    chk("sq_t2_req", 32'(mem_req), 0);
    tick;
    chk("sq_t3_pend", 32'(pend_cnt), 0);
    chk("sq_t3_del", 32'(del), 0);
    // data not yet valid stalls the request
    mem_ack = 1'b0; sq_head = mk(1, 0, 8'h11, 32'h12345678); commit_st = 1'b1;
    tick; commit_st = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("nd_req0", 32'(mem_req), 0);
    end
    sq_head = mk(1, 1, 8'h11, 32'h12345678);
    tick;
    chk("nd_req1", 32'(mem_req), 1);
    chk("nd_addr", 32'(mem_addr), 32'h11);
    mem_ack = 1'b1;
    tick; mem_ack = 1'b0;
    chk("nd_del", 32'(del), 1);
    tick;
    chk("nd_pend0", 32'(pend_cnt), 0);
    // nine back-to-back commits saturate at eight
    sq_head = mk(1, 1, 8'h55, 32'hCAFEF00D); commit_st = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick;
      if (i == 7) begin
        chk("sat_pend8", 32'(pend_cnt), 8);
        chk("sat_ovf0", 32'(overflow), 0);
      end
    end
    commit_st = 1'b0;
    chk("sat_pend", 32'(pend_cnt), 8);
    chk("sat_ovf", 32'(overflow), 1);
    chk("sat_req", 32'(mem_req), 1);
    sq_head = mk(1, 1, 8'h66, 32'h0);
    tick;
    chk("sat_addr", 32'(mem_addr), 32'h55);
    chk("sat_data", mem_wdata, 32'hCAFEF00D);
    chk("sat_req_hold", 32'(mem_req), 1);
    chk("sat_ovf_sticky", 32'(overflow), 1);
    // reset clears overflow; commit coincident with del holds the count
    rstn = 1'b0; #1;
    chk("rst2_ovf", 32'(overflow), 0);
    chk("rst2_pend", 32'(pend_cnt), 0);
    @(negedge clk) rstn = 1'b1;
    sq_head = mk(1, 1, 8'h33, 32'h0BADF00D); commit_st = 1'b1;
    tick; tick; tick; commit_st = 1'b0;
    chk("co_pend3", 32'(pend_cnt), 3);
    chk("co_req", 32'(mem_req), 1);
    mem_ack = 1'b1;
    tick; mem_ack = 1'b0;
    chk("co_del", 32'(del), 1);
    chk("co_pend_rel", 32'(pend_cnt), 3);
    commit_st = 1'b1;
    tick; commit_st = 1'b0;
    chk("co_pend_same", 32'(pend_cnt), 3);
    chk("co_idle", 32'(busy), 0);
    // asynchronous reset in the middle of a write
    tick;
    chk("ar_req1", 32'(mem_req), 1);
    #2 rstn = 1'b0;
    #1;
    chk("ar_req0", 32'(mem_req), 0);
    chk("ar_pend0", 32'(pend_cnt), 0);
    chk("ar_del", 32'(del), 0);
    chk("ar_busy", 32'(busy), 0);
    tick;
    chk("ar_del_held", 32'(del), 0);
    @(negedge clk) rstn = 1'b1; mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("ar_no_del", 32'(del), 0);
      chk("ar_no_req", 32'(mem_req), 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
